cp0_cause_ctrl: RTL and testbench

- Parametrised CP0 Cause-register controller for the MIPS54 core; generalises the fixed 2-input cause lookup.
- Takes N prioritised synchronous exception requests plus M asynchronous hardware interrupt lines.
- Holds the architectural Cause register (BD, IP, ExcCode) and runs a small handler-state FSM (idle/in-handler) with an eret handshake.
- Sits between the pipeline's exception-detect logic and the CP0 register file / PC-redirect logic.

---
 rtl/cp0_cause_ctrl_pkg.sv | 21 ++
 rtl/cp0_cause_ctrl_if.sv | 28 ++
 rtl/cp0_cause_ctrl_int_sync.sv | 25 ++
 rtl/cp0_cause_ctrl.sv | 121 ++++++++++++
 tb/tb_cp0_cause_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_cause_ctrl_pkg.sv
// Shared definitions for the CP0 Cause controller: ExcCode values, Cause field
// positions and the handler FSM encoding.
package cp0_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_TR  = 5'd13;

    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StHandler = 1'b1
    } cause_state_e;

endpackage

// File: rtl/cp0_cause_ctrl_if.sv
// Bus between the pipeline exception logic and the Cause controller.
interface cp0_cause_if #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned NUM_HW_INT = 6
);
    logic [NUM_SRC-1:0]    exc_req;
    logic                  in_delay_slot;
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  int_en;
    logic                  mtc0_we;
    logic [31:0]           mtc0_data;
    logic                  eret;
    logic [31:0]           cause;
    logic                  exc_take;
    logic                  exl;
    logic                  int_pending;

    modport master (
        output exc_req, in_delay_slot, hw_int, int_en, mtc0_we, mtc0_data, eret,
        input  cause, exc_take, exl, int_pending
    );

    modport slave (
        input  exc_req, in_delay_slot, hw_int, int_en, mtc0_we, mtc0_data, eret,
        output cause, exc_take, exl, int_pending
    );

endinterface

// File: rtl/cp0_cause_ctrl_int_sync.sv
// Multi-stage synchroniser for the asynchronous hardware interrupt lines.
module int_sync #(
    parameter int unsigned Width  = 6,
    parameter int unsigned Stages = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Stages); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(Stages); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/cp0_cause_ctrl.sv
// CP0 Cause register controller: prioritised exception capture, interrupt
// acceptance and the idle/in-handler FSM with eret return.
module cp0_cause_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned             NUM_SRC     = 3,
    parameter logic [5*NUM_SRC-1:0]    EXC_CODES   = {EXC_TR, EXC_BP, EXC_SYS},
    parameter int unsigned             NUM_HW_INT  = 6,
    parameter int unsigned             SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    cp0_cause_if.slave bus
);

    if (NUM_HW_INT < 1 || NUM_HW_INT > 6) begin : gen_bad_hw_int
        $error("NUM_HW_INT must be in 1..6");
    end
    if (SYNC_STAGES < 2) begin : gen_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    cause_state_e          state_q, state_d;
    logic [4:0]            exc_q, exc_d;
    logic                  bd_q, bd_d;
    logic [1:0]            sw_ip_q, sw_ip_d;
    logic                  exc_take_q;
    logic [NUM_HW_INT-1:0] hw_sync;
    logic [5:0]            hw_ip;
    logic [7:0]            ip;
    logic [4:0]            sel_code;
    logic                  req_any;
    logic                  accept;
    logic                  exl;
    logic                  unused_mtc0;

    int_sync #(
        .Width (NUM_HW_INT),
        .Stages(SYNC_STAGES)
    ) u_int_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (bus.hw_int),
        .q_o  (hw_sync)
    );

    // Hw IP bits follow the synchroniser directly; they are never latched.
    always_comb begin
        hw_ip = '0;
        hw_ip[NUM_HW_INT-1:0] = hw_sync;
    end

    assign ip      = {hw_ip, sw_ip_q};
    assign req_any = |bus.exc_req;

    // Scan downward so the lowest set index wins.
    always_comb begin
        sel_code = EXC_INT;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (bus.exc_req[i]) sel_code = EXC_CODES[5*i +: 5];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept)   state_d = StHandler;
            StHandler: if (bus.eret) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        exl    = (state_q == StHandler);
        accept = (state_q == StIdle) && (req_any || bus.int_pending);
    end

    always_comb begin
        exc_d   = exc_q;
        bd_d    = bd_q;
        sw_ip_d = sw_ip_q;
        if (accept) begin
            exc_d = req_any ? sel_code : EXC_INT;
            bd_d  = bus.in_delay_slot;
        end
        if (bus.mtc0_we) sw_ip_d = bus.mtc0_data[9:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q      <= '0;
            bd_q       <= 1'b0;
            sw_ip_q    <= '0;
            exc_take_q <= 1'b0;
        end else begin
            exc_q      <= exc_d;
            bd_q       <= bd_d;
            sw_ip_q    <= sw_ip_d;
            exc_take_q <= accept;
        end
    end

    always_comb begin
        bus.cause = '0;
        bus.cause[CAUSE_BD]                  = bd_q;
        bus.cause[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        bus.cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    end

    assign bus.int_pending = bus.int_en & (|ip);
    assign bus.exc_take    = exc_take_q;
    assign bus.exl         = exl;

    assign unused_mtc0 = ^{bus.mtc0_data[31:10], bus.mtc0_data[7:0]};

endmodule

// File: tb/tb_cp0_cause_ctrl.sv
// Self-checking bench for cp0_cause_ctrl: directed scenarios plus randomized
// traffic against a behavioural model of the Cause register.
module tb_cp0_cause_ctrl;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cp0_cause_if #(.NUM_SRC(3), .NUM_HW_INT(6)) bus ();

    cp0_cause_ctrl #(
        .NUM_SRC    (3),
        .EXC_CODES  ({5'd13, 5'd9, 5'd8}),
        .NUM_HW_INT (6),
        .SYNC_STAGES(S)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit         m_hand;
    logic [4:0] m_exc;
    bit         m_bd;
    logic [1:0] m_sw;
    bit         m_take;
    logic [5:0] m_hwq[$];
    logic [4:0] codes[3] = '{5'd8, 5'd9, 5'd13};

    function automatic logic [7:0] m_ip();
        return {m_hwq[S-1], m_sw};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, 15'b0, m_ip(), 1'b0, m_exc, 2'b0};
    endfunction

    task automatic model_reset();
        m_hand = 0; m_exc = '0; m_bd = 0; m_sw = '0; m_take = 0;
        m_hwq = {};
        repeat (S) m_hwq.push_front(6'b0);
    endtask

    task automatic model_edge();
        logic [7:0] ip;
        bit pend;
        ip   = m_ip();
        pend = bus.int_en && (ip != 0);
        m_take = 0;
        if (!m_hand) begin
            if (bus.exc_req != 0) begin
                for (int i = 0; i < 3; i++) begin
                    if (bus.exc_req[i]) begin
                        m_exc = codes[i];
                        break;
                    end
                end
                m_bd = bus.in_delay_slot; m_hand = 1; m_take = 1;
            end else if (pend) begin
                m_exc = 5'd0; m_bd = bus.in_delay_slot; m_hand = 1; m_take = 1;
            end
        end else if (bus.eret) begin
            m_hand = 0;
        end
        if (bus.mtc0_we) m_sw = bus.mtc0_data[9:8];
        m_hwq.push_front(bus.hw_int);
        void'(m_hwq.pop_back());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.exc_req = '0; bus.in_delay_slot = 0; bus.hw_int = '0; bus.int_en = 0;
        bus.mtc0_we = 0; bus.mtc0_data = '0; bus.eret = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        bus.exc_req = 3'b001;
        tick();
        bus.exc_req = '0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (bus.cause !== 32'h0 || bus.exl !== 1'b0 || bus.exc_take !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: cause=%h exl=%b take=%b, required 0/0/0",
                     bus.cause, bus.exl, bus.exc_take);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        tick();
        checks++;
        if (bus.cause !== 32'h0 || bus.exl !== 1'b0 || bus.exc_take !== 1'b0 ||
            bus.int_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cause=%h exl=%b take=%b pend=%b, required all 0",
                     bus.cause, bus.exl, bus.exc_take, bus.int_pending);
        end
    endtask

    task automatic test_syscall();
        bus.exc_req = 3'b001; bus.in_delay_slot = 0;
        tick();
        bus.exc_req = '0;
        checks++;
        if (bus.cause !== 32'h0000_0020 || bus.exc_take !== 1'b1 || bus.exl !== 1'b1) begin
            errors++;
            $display("FAIL syscall_take: cause=%h take=%b exl=%b, required 00000020/1/1",
                     bus.cause, bus.exc_take, bus.exl);
        end
        tick();
        checks++;
        if (bus.exc_take !== 1'b0 || bus.exl !== 1'b1) begin
            errors++;
            $display("FAIL syscall_pulse: take=%b exl=%b, required 0/1", bus.exc_take, bus.exl);
        end
        bus.eret = 1;
        tick();
        bus.eret = 0;
        checks++;
        if (bus.exl !== 1'b0 || bus.cause !== 32'h0000_0020) begin
            errors++;
            $display("FAIL syscall_eret: exl=%b cause=%h, required 0/00000020", bus.exl, bus.cause);
        end
    endtask

    task automatic test_priority_bd();
        bus.exc_req = 3'b110; bus.in_delay_slot = 1;
        tick();
        bus.exc_req = '0; bus.in_delay_slot = 0;
        checks++;
        if (bus.cause !== 32'h8000_0024 || bus.exc_take !== 1'b1) begin
            errors++;
            $display("FAIL prio_bd: cause=%h take=%b, required 80000024/1", bus.cause, bus.exc_take);
        end
        bus.exc_req = 3'b001;
        tick();
        bus.exc_req = '0;
        checks++;
        if (bus.cause !== 32'h8000_0024 || bus.exc_take !== 1'b0 || bus.exl !== 1'b1) begin
            errors++;
            $display("FAIL handler_ignore: cause=%h take=%b exl=%b, required 80000024/0/1",
                     bus.cause, bus.exc_take, bus.exl);
        end
    endtask

    task automatic test_eret_race();
        bus.eret = 1; bus.exc_req = 3'b100;
        tick();
        bus.eret = 0;
        checks++;
        if (bus.exl !== 1'b0 || bus.exc_take !== 1'b0) begin
            errors++;
            $display("FAIL eret_race: exl=%b take=%b, required 0/0", bus.exl, bus.exc_take);
        end
        tick();
        bus.exc_req = '0;
        checks++;
        if (bus.cause !== 32'h0000_0034 || bus.exc_take !== 1'b1 || bus.exl !== 1'b1) begin
            errors++;
            $display("FAIL eret_retake: cause=%h take=%b exl=%b, required 00000034/1/1",
                     bus.cause, bus.exc_take, bus.exl);
        end
        bus.eret = 1;
        tick();
        bus.eret = 0;
    endtask

    task automatic test_interrupt();
        bus.int_en = 1; bus.hw_int = 6'b000001;
        tick();
        checks++;
        if (bus.cause[10] !== 1'b0 || bus.exl !== 1'b0) begin
            errors++;
            $display("FAIL int_sync_early: ip2=%b exl=%b, required 0/0", bus.cause[10], bus.exl);
        end
        tick();
        checks++;
        if (bus.cause[10] !== 1'b1 || bus.int_pending !== 1'b1 || bus.exc_take !== 1'b0) begin
            errors++;
            $display("FAIL int_sync_arrive: ip2=%b pend=%b take=%b, required 1/1/0",
                     bus.cause[10], bus.int_pending, bus.exc_take);
        end
        tick();
        checks++;
        if (bus.cause[6:2] !== 5'd0 || bus.exc_take !== 1'b1 || bus.exl !== 1'b1) begin
            errors++;
            $display("FAIL int_take: exc=%0d take=%b exl=%b, required 0/1/1",
                     bus.cause[6:2], bus.exc_take, bus.exl);
        end
        bus.hw_int = '0;
        tick();
        tick();
        checks++;
        if (bus.cause[10] !== 1'b0 || bus.exl !== 1'b1) begin
            errors++;
            $display("FAIL int_release: ip2=%b exl=%b, required 0/1", bus.cause[10], bus.exl);
        end
        bus.int_en = 0; bus.eret = 1;
        tick();
        bus.eret = 0;
    endtask

    task automatic test_sw_ip();
        apply_reset();
        bus.int_en = 0; bus.mtc0_we = 1; bus.mtc0_data = 32'hFFFF_FFFF;
        tick();
        bus.mtc0_we = 0; bus.mtc0_data = '0;
        checks++;
        if (bus.cause !== 32'h0000_0300 || bus.exc_take !== 1'b0 || bus.int_pending !== 1'b0) begin
            errors++;
            $display("FAIL sw_ip_write: cause=%h take=%b pend=%b, required 00000300/0/0",
                     bus.cause, bus.exc_take, bus.int_pending);
        end
        bus.int_en = 1;
        #1;
        checks++;
        if (bus.int_pending !== 1'b1) begin
            errors++;
            $display("FAIL sw_ip_pending: pend=%b, required 1", bus.int_pending);
        end
        tick();
        checks++;
        if (bus.exc_take !== 1'b1 || bus.exl !== 1'b1 || bus.cause !== 32'h0000_0300) begin
            errors++;
            $display("FAIL sw_ip_take: take=%b exl=%b cause=%h, required 1/1/00000300",
                     bus.exc_take, bus.exl, bus.cause);
        end
        bus.int_en = 0; bus.mtc0_we = 1; bus.eret = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [31:0] exp_cause;
        bit exp_pend;
        for (int n = 0; n < 400; n++) begin
            bus.exc_req       = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            bus.in_delay_slot = 1'($urandom);
            bus.eret          = ($urandom_range(0, 2) == 0);
            bus.int_en        = 1'($urandom);
            bus.mtc0_we       = ($urandom_range(0, 7) == 0);
            bus.mtc0_data     = $urandom;
            if ($urandom_range(0, 9) == 0) bus.hw_int[$urandom_range(0, 5)] ^= 1'b1;
            tick();
            exp_cause = m_cause();
            exp_pend  = bus.int_en && (m_ip() != 0);
            checks++;
            if (bus.cause !== exp_cause) begin
                errors++;
                $display("FAIL rand_cause[%0d]: got %h, required %h", n, bus.cause, exp_cause);
            end
            checks++;
            if (bus.exc_take !== m_take) begin
                errors++;
                $display("FAIL rand_take[%0d]: got %b, required %b", n, bus.exc_take, m_take);
            end
            checks++;
            if (bus.exl !== m_hand) begin
                errors++;
                $display("FAIL rand_exl[%0d]: got %b, required %b", n, bus.exl, m_hand);
            end
            checks++;
            if (bus.int_pending !== exp_pend) begin
                errors++;
                $display("FAIL rand_pend[%0d]: got %b, required %b", n, bus.int_pending, exp_pend);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        test_reset();
        test_syscall();
        test_priority_bd();
        test_eret_race();
        test_interrupt();
        test_sw_ip();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
